axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
AXI4 (full) memory-mapped responder that backs the AXI master under verification. It accepts INCR write bursts into an internal register-file memory and serves INCR read bursts from that memory. It sits on the slave side of the verification block design at base address 0xC0000000. It lets master write/read-back tests (16 x 32-bit beats) run without a vendor BRAM controller.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; only 32 is supported
MEM_DEPTH, 64, number of DATA_WIDTH words in internal memory
BASE_ADDR, 32'hC0000000, byte address of word 0

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  bytes per beat (log2)
s_axi_awburst  in  2  burst type
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  ADDR_WIDTH  read burst start byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  bytes per beat (log2)
s_axi_arburst  in  2  burst type
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- Reset, asynchronous: both FSMs go to IDLE.
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=0, rresp=0, rdata=0.
  - Memory contents are not reset.
- Reset asserted mid-burst: the burst is abandoned and no further beats are written or returned.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch addr, len, and error flag; beat counter=0; next state W_DATA.
  - W_DATA: wready=1. On each wvalid&wready:
    - Write memory bytes selected by wstrb at word index (addr-BASE_ADDR)>>2.
    - Increment addr by 4 and the counter.
    - On the beat where counter==len, go to W_RESP.
  - The burst always ends on counter==len; wlast is ignored for termination.
  - wlast mismatch (wlast=1 before the final beat, or wlast=0 on the final beat) sets SLVERR.
  - W_RESP: bvalid=1, bresp=error code, held until bready. Then W_IDLE, with awready=1 in the next cycle.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, latch addr, len, and error flag.
  - rvalid asserts the next cycle with the first beat registered.
  - R_DATA: rdata, rresp, and rlast hold stable while rvalid&!rready.
  - On rvalid&rready, the next beat is presented the following cycle, so full throughput is 1 beat/cycle.
  - rlast=1 exactly on beat len. After its handshake, rvalid=0 and the FSM returns to R_IDLE.
- Error rules (worst error wins; DECERR > SLVERR > OKAY):
  - burst != INCR (2'b01) -> SLVERR, and the address still increments.
  - size != 3'b010 -> SLVERR.
  - A beat with word index outside 0..MEM_DEPTH-1, including addr < BASE_ADDR, -> DECERR for that beat.
    - That write beat is dropped.
    - That read beat returns rdata=0.
  - An SLVERR burst performs no memory writes; its reads return rdata=0.
  - bresp is the aggregate of all beats. rresp is per beat.
- No 4 KB boundary check is performed; the address wraps modulo 2^ADDR_WIDTH.
- Channels are independent; a read and a write may be in flight together.
- Same-cycle read and write to the same word: the read gets the old data (read-before-write).
- Single outstanding transaction per direction: awready=0 outside W_IDLE and arready=0 outside R_IDLE.

Test Plan:
- Write awaddr=0xC0000000, awlen=15, wdata=i for beat i (0..15), wstrb=4'hF.
  - Required: bresp=OKAY one cycle after the last beat.
  - Then read the same range with arlen=15: rdata=0..15 in order, rresp=OKAY, and rlast only on the 16th beat.
- Write 0xAABBCCDD to 0xC0000004 with wstrb=4'b0101 over prior data 0x00000001.
  - Required: readback 0x00BB00DD.
- Write awaddr=0xC00000F8 with awlen=3 (MEM_DEPTH=64).
  - Required: beats 0-1 are stored, beats 2-3 are dropped, and bresp=DECERR.
  - Reading the same range gives rresp OKAY, OKAY, DECERR, DECERR with the last two rdata=0.
- 16-beat read with rready toggled 1,0,0,1 repeatedly.
  - Required: no beat lost or duplicated.
  - rdata and rlast stay stable while stalled, and the read completes in exactly 16 handshakes.
- Assert reset during beat 5 of a 16-beat write.
  - Required: bvalid=0 and awready=1 immediately.
  - A fresh 1-beat write to 0xC0000000 then completes with OKAY.
- Issue awburst=2'b00 with arsize=3'b011 on a concurrent read.
  - Required: bresp=SLVERR with memory unchanged, and every read beat has rresp=SLVERR.

Source files
------------

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 bus bundle for the burst memory responder: AW/W/B/AR/R channels.
// Signal names keep the s_axi_ prefix of the responder's port list.
interface axi_burst_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic [2:0]              s_axi_awsize;
    logic [1:0]              s_axi_awburst;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wlast;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic [2:0]              s_axi_arsize;
    logic [1:0]              s_axi_arburst;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-burst responder backed by a register-file memory at BASE_ADDR.
// Independent write (IDLE/DATA/RESP) and read (IDLE/DATA) engines, one burst each.
module axi_burst_mem_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hC0000000
) (
    input logic                  clk,
    input logic                  reset,
    axi_burst_mem_slave_if.slave axi
);
    localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned           STRB_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC  = ADDR_WIDTH'(4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    // Response codes are ordered so that the numerically larger one is the worse one.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] hdr_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst != 2'b01 || size != 3'b010) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [1:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            werr_q, werr_d, wacc_q, wacc_d, bresp_q, bresp_d;
    logic                  r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rerr_q, rerr_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;

    logic [ADDR_WIDTH-1:0] w_off, rd_addr, rd_off;
    logic                  w_in_range, rd_in_range, mem_we;
    logic [IDX_W-1:0]      w_idx, rd_idx;
    logic [DATA_WIDTH-1:0] w_mask, rd_word, rd_beat_data;
    logic [1:0]            w_beat_err, wlast_err, w_total, rd_hdr, rd_beat_resp;

    // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range too.
    assign w_off      = waddr_q - BASE_ADDR;
    assign w_in_range = w_off < MEM_BYTES;
    assign w_idx      = w_off[IDX_W+1:2];

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wmask
        assign w_mask[gi*8 +: 8] = {8{axi.s_axi_wstrb[gi]}};
    end

    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        wacc_d     = wacc_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        w_beat_err = w_in_range ? RESP_OKAY : RESP_DECERR;
        wlast_err  = (axi.s_axi_wlast != (wcnt_q == wlen_q)) ? RESP_SLVERR : RESP_OKAY;
        w_total    = worst(wacc_q, worst(w_beat_err, wlast_err));
        case (w_state_q)
            W_IDLE: if (axi.s_axi_awvalid) begin
                waddr_d   = axi.s_axi_awaddr;
                wlen_d    = axi.s_axi_awlen;
                wcnt_d    = 8'd0;
                werr_d    = hdr_err(axi.s_axi_awburst, axi.s_axi_awsize);
                wacc_d    = werr_d;
                w_state_d = W_DATA;
            end
            W_DATA: if (axi.s_axi_wvalid) begin
                mem_we  = (werr_q == RESP_OKAY) && w_in_range;
                waddr_d = waddr_q + BEAT_INC;
                wcnt_d  = wcnt_q + 8'd1;
                wacc_d  = w_total;
                // Termination follows the beat count; wlast only feeds the response.
                if (wcnt_q == wlen_q) begin
                    bresp_d   = w_total;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (axi.s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Next read beat comes from the AR request while idle, else from the running pointer.
    assign rd_addr      = (r_state_q == R_IDLE) ? axi.s_axi_araddr : raddr_q;
    assign rd_hdr       = (r_state_q == R_IDLE) ? hdr_err(axi.s_axi_arburst, axi.s_axi_arsize) : rerr_q;
    assign rd_off       = rd_addr - BASE_ADDR;
    assign rd_in_range  = rd_off < MEM_BYTES;
    assign rd_idx       = rd_off[IDX_W+1:2];
    assign rd_word      = mem_q[rd_idx];
    assign rd_beat_data = (rd_hdr == RESP_OKAY && rd_in_range) ? rd_word : '0;
    assign rd_beat_resp = worst(rd_hdr, rd_in_range ? RESP_OKAY : RESP_DECERR);

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: if (axi.s_axi_arvalid) begin
                rerr_d    = rd_hdr;
                rlen_d    = axi.s_axi_arlen;
                rcnt_d    = 8'd0;
                raddr_d   = axi.s_axi_araddr + BEAT_INC;
                rdata_d   = rd_beat_data;
                rresp_d   = rd_beat_resp;
                rlast_d   = (axi.s_axi_arlen == 8'd0);
                r_state_d = R_DATA;
            end
            R_DATA: if (axi.s_axi_rready) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rdata_d = rd_beat_data;
                    rresp_d = rd_beat_resp;
                    rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    rcnt_d  = rcnt_q + 8'd1;
                    raddr_d = raddr_q + BEAT_INC;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= RESP_OKAY;
            wacc_q    <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rerr_q    <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            wacc_q    <= wacc_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Contents survive reset; a same-cycle read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[w_idx] <= (mem_q[w_idx] & ~w_mask) | (axi.s_axi_wdata & w_mask);
    end

    assign axi.s_axi_awready = (w_state_q == W_IDLE);
    assign axi.s_axi_wready  = (w_state_q == W_DATA);
    assign axi.s_axi_bvalid  = (w_state_q == W_RESP);
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_arready = (r_state_q == R_IDLE);
    assign axi.s_axi_rvalid  = (r_state_q == R_DATA);
    assign axi.s_axi_rdata   = rdata_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_rlast   = rlast_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: bursts, strobes, range errors, stalls, reset, SLVERR.
`timescale 1ns/1ps
module tb_axi_burst_mem_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_burst_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_burst_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .BASE_ADDR(32'hC0000000)
    ) dut (
        .clk(clk), .reset(reset), .axi(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_cnt;
    logic [1:0]  bresp_got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, output logic [1:0] resp);
        int c;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len;
        bus.s_axi_awburst = burst;
        bus.s_axi_awsize  = size;
        bus.s_axi_awvalid = 1'b1;
        c = 0;
        while (!bus.s_axi_awready && c < 50) begin step(); c++; end
        check("awready_seen", 32'(bus.s_axi_awready), 32'd1);
        step();
        bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = wd[i];
            bus.s_axi_wstrb  = ws[i];
            bus.s_axi_wlast  = (i == int'(len));
            c = 0;
            while (!bus.s_axi_wready && c < 50) begin step(); c++; end
            check("wready_seen", 32'(bus.s_axi_wready), 32'd1);
            step();
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
        check("bvalid_after_last_beat", 32'(bus.s_axi_bvalid), 32'd1);
        resp = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        check("bvalid_cleared", 32'(bus.s_axi_bvalid), 32'd0);
        check("awready_back", 32'(bus.s_axi_awready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic stall);
        int c;
        int cyc;
        logic held;
        logic [31:0] held_d;
        logic held_l;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arburst = burst;
        bus.s_axi_arsize  = size;
        bus.s_axi_arvalid = 1'b1;
        c = 0;
        while (!bus.s_axi_arready && c < 50) begin step(); c++; end
        check("arready_seen", 32'(bus.s_axi_arready), 32'd1);
        step();
        bus.s_axi_arvalid = 1'b0;
        check("rvalid_next_cycle", 32'(bus.s_axi_rvalid), 32'd1);
        rd_cnt = 0;
        cyc = 0;
        held = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (rd_cnt <= int'(len) && cyc < 200) begin
            bus.s_axi_rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (held) begin
                check("stall_rdata_stable", bus.s_axi_rdata, held_d);
                check("stall_rlast_stable", 32'(bus.s_axi_rlast), 32'(held_l));
            end
            held = 1'b0;
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                rd_data[rd_cnt] = bus.s_axi_rdata;
                rd_resp[rd_cnt] = bus.s_axi_rresp;
                rd_last[rd_cnt] = bus.s_axi_rlast;
                rd_cnt++;
            end else if (bus.s_axi_rvalid) begin
                held   = 1'b1;
                held_d = bus.s_axi_rdata;
                held_l = bus.s_axi_rlast;
            end
            step();
            cyc++;
        end
        bus.s_axi_rready = 1'b0;
        check("read_handshakes", 32'(rd_cnt), 32'(int'(len) + 1));
        check("rvalid_after_last", 32'(bus.s_axi_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = 3'b010; bus.s_axi_awburst = 2'b01;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = 3'b010; bus.s_axi_arburst = 2'b01;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

        // Reset state
        step();
        check("rst_awready", 32'(bus.s_axi_awready), 32'd1);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd1);
        check("rst_wready",  32'(bus.s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
        check("rst_rlast",   32'(bus.s_axi_rlast),   32'd0);
        check("rst_bresp",   32'(bus.s_axi_bresp),   32'd0);
        check("rst_rresp",   32'(bus.s_axi_rresp),   32'd0);
        check("rst_rdata",   bus.s_axi_rdata,        32'd0);
        step();
        reset = 1'b0;
        step();

        // 16-beat write of 0..15 then readback
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        do_write(32'hC0000000, 8'd15, 2'b01, 3'b010, bresp_got);
        check("t1_bresp", 32'(bresp_got), 32'd0);
        do_read(32'hC0000000, 8'd15, 2'b01, 3'b010, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_rdata[%0d]", i), rd_data[i], 32'(i));
            check($sformatf("t1_rresp[%0d]", i), 32'(rd_resp[i]), 32'd0);
            check($sformatf("t1_rlast[%0d]", i), 32'(rd_last[i]), 32'(i == 15));
        end

        // Byte strobes 0101 over 0x00000001
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'hC0000004, 8'd0, 2'b01, 3'b010, bresp_got);
        check("t2_bresp", 32'(bresp_got), 32'd0);
        do_read(32'hC0000004, 8'd0, 2'b01, 3'b010, 1'b0);
        check("t2_rdata", rd_data[0], 32'h00BB00DD);
        check("t2_rlast", 32'(rd_last[0]), 32'd1);

        // Burst running off the end of memory
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(32'hC00000F8, 8'd3, 2'b01, 3'b010, bresp_got);
        check("t3_bresp", 32'(bresp_got), 32'd3);
        do_read(32'hC00000F8, 8'd3, 2'b01, 3'b010, 1'b0);
        check("t3_rdata0", rd_data[0], 32'h11);
        check("t3_rdata1", rd_data[1], 32'h22);
        check("t3_rdata2", rd_data[2], 32'h0);
        check("t3_rdata3", rd_data[3], 32'h0);
        check("t3_rresp0", 32'(rd_resp[0]), 32'd0);
        check("t3_rresp1", 32'(rd_resp[1]), 32'd0);
        check("t3_rresp2", 32'(rd_resp[2]), 32'd3);
        check("t3_rresp3", 32'(rd_resp[3]), 32'd3);
        do_read(32'hC0000000, 8'd1, 2'b01, 3'b010, 1'b0);
        check("t3_no_alias_w0", rd_data[0], 32'h0);
        check("t3_no_alias_w1", rd_data[1], 32'h00BB00DD);

        // Stalled read with rready 1,0,0,1
        do_read(32'hC0000000, 8'd15, 2'b01, 3'b010, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_rdata[%0d]", i), rd_data[i], (i == 1) ? 32'h00BB00DD : 32'(i));
            check($sformatf("t4_rlast[%0d]", i), 32'(rd_last[i]), 32'(i == 15));
        end

        // Reset during beat 5 of a 16-beat write at word 8
        for (int i = 0; i < 16; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        bus.s_axi_awaddr = 32'hC0000020; bus.s_axi_awlen = 8'd15;
        bus.s_axi_awburst = 2'b01; bus.s_axi_awsize = 3'b010; bus.s_axi_awvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0;
        check("t5_wready", 32'(bus.s_axi_wready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = wd[i]; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b0;
            step();
        end
        bus.s_axi_wdata = wd[5];
        reset = 1'b1;
        #1;
        check("t5_rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        check("t5_rst_awready", 32'(bus.s_axi_awready), 32'd1);
        check("t5_rst_wready",  32'(bus.s_axi_wready),  32'd0);
        bus.s_axi_wvalid = 1'b0;
        step();
        reset = 1'b0;
        step();
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(32'hC0000000, 8'd0, 2'b01, 3'b010, bresp_got);
        check("t5_fresh_bresp", 32'(bresp_got), 32'd0);
        do_read(32'hC0000020, 8'd5, 2'b01, 3'b010, 1'b0);
        for (int i = 0; i < 5; i++)
            check($sformatf("t5_kept[%0d]", i), rd_data[i], 32'hA0 + 32'(i));
        check("t5_beat5_dropped", rd_data[5], 32'd13);

        // SLVERR write (burst FIXED) concurrent with SLVERR read (size 8 bytes)
        wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF; ws[0] = 4'hF; ws[1] = 4'hF;
        fork
            do_write(32'hC0000000, 8'd1, 2'b00, 3'b010, bresp_got);
            do_read(32'hC0000000, 8'd1, 2'b01, 3'b011, 1'b0);
        join
        check("t6_bresp", 32'(bresp_got), 32'd2);
        check("t6_rresp0", 32'(rd_resp[0]), 32'd2);
        check("t6_rresp1", 32'(rd_resp[1]), 32'd2);
        check("t6_rdata0", rd_data[0], 32'd0);
        check("t6_rdata1", rd_data[1], 32'd0);
        check("t6_rlast1", 32'(rd_last[1]), 32'd1);
        do_read(32'hC0000000, 8'd1, 2'b01, 3'b010, 1'b0);
        check("t6_mem_w0", rd_data[0], 32'h12345678);
        check("t6_mem_w1", rd_data[1], 32'h00BB00DD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
